// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared types and constants for the SPI command sequencer.
package spi_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CWR,
        ST_CRD,
        ST_PWR,
        ST_DISCARD
    } state_t;

    localparam logic [7:0]  CMD_NON      = 8'd0;
    localparam logic [7:0]  CMD_CSR_WR   = 8'd1;
    localparam logic [7:0]  CMD_CSR_RD   = 8'd2;
    localparam logic [7:0]  CMD_PSRAM_WR = 8'd3;

    localparam int          HDR_BYTES    = 8;
    localparam logic [15:0] CSR_LEN      = 16'd4;

    localparam logic [7:0]  PAD_BYTE     = 8'h00;
    localparam logic [7:0]  ERR_BYTE     = 8'hFF;

    // CSR commands take ownership of the Usi bus for the whole frame
    function automatic logic isCsrCmd(input logic [7:0] cmd);
        return (cmd == CMD_CSR_WR) || (cmd == CMD_CSR_RD);
    endfunction

endpackage

// File: rtl/spi_cmd_sequencer_if.sv
// Byte-stream and bus signals between the SPI shifter, the sequencer and the Usi/Ufi buses.
interface spi_cmd_sequencer_if #(
    parameter int pUsiAdrsBit = 16
);
    logic                   iSpiCsAct;
    logic [7:0]             iRxByte;
    logic                   iRxVd;
    logic                   iTxReq;
    logic [7:0]             oTxByte;
    logic [31:0]            oMUsiWd;
    logic [pUsiAdrsBit-1:0] oMUsiAdrs;
    logic                   oMUsiWEd;
    logic                   oMUsiRCke;
    logic [31:0]            iMUsiRd;
    logic                   iMUsiREd;
    logic [31:0]            oMUfiWd;
    logic [31:0]            oMUfiAdrs;
    logic                   oMUfiWEd;
    logic                   oMUfiWVd;
    logic                   oMUsiMonopoly;
    logic                   oErr;

    modport slave (
        input  iSpiCsAct, iRxByte, iRxVd, iTxReq, iMUsiRd, iMUsiREd,
        output oTxByte, oMUsiWd, oMUsiAdrs, oMUsiWEd, oMUsiRCke,
               oMUfiWd, oMUfiAdrs, oMUfiWEd, oMUfiWVd, oMUsiMonopoly, oErr
    );

    modport master (
        output iSpiCsAct, iRxByte, iRxVd, iTxReq, iMUsiRd, iMUsiREd,
        input  oTxByte, oMUsiWd, oMUsiAdrs, oMUsiWEd, oMUsiRCke,
               oMUfiWd, oMUfiAdrs, oMUfiWEd, oMUfiWVd, oMUsiMonopoly, oErr
    );

endinterface

// File: rtl/spi_cmd_sequencer_word_packer.sv
// Packs MSB-first bytes into 32-bit words; a flagged last byte flushes a
// partial word with zero padding in the low bytes.
module spi_word_packer
    import spi_cmd_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_byteVd,
    input  logic [7:0]  i_byte,
    input  logic        i_last,
    output logic [31:0] o_word,
    output logic        o_wordDone
);

    logic [23:0] r_acc;
    logic [1:0]  r_cnt;
    logic [31:0] w_word;

    // Word as it would look if the current byte completes it, padded when partial
    always_comb begin
        w_word = {r_acc, i_byte};
        case (r_cnt)
            2'd0:    w_word = {i_byte, {3{PAD_BYTE}}};
            2'd1:    w_word = {r_acc[7:0], i_byte, {2{PAD_BYTE}}};
            2'd2:    w_word = {r_acc[15:0], i_byte, PAD_BYTE};
            default: w_word = {r_acc, i_byte};
        endcase
    end

    assign o_word     = w_word;
    assign o_wordDone = i_byteVd && ((r_cnt == 2'd3) || i_last);

    // Accumulate bytes, restart after each emitted word or on clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_byteVd) begin
            if (o_wordDone) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= {r_acc[15:0], i_byte};
                r_cnt <= r_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// SPI command sequencer: parses the 8-byte header, then runs a CSR write,
// a CSR read served over MISO, or a PSRAM word stream.
module spi_cmd_sequencer
    import spi_cmd_pkg::*;
#(
    parameter int pUsiAdrsBit = 16,
    parameter int pMaxLen     = 2048,
    parameter int pRdTimeout  = 255
)(
    input  logic iSysClk,
    input  logic iSysRst,
    spi_cmd_sequencer_if.slave bus
);

    localparam int               TMR_W    = $clog2(pRdTimeout + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(pRdTimeout - 1);
    localparam logic [16:0]      MAX_LEN  = 17'(pMaxLen);

    state_t           r_state;
    logic             r_csPrev;
    logic [2:0]       r_hdrCnt;
    logic [31:0]      r_adrs;
    logic [7:0]       r_cmd;
    logic [15:0]      r_len;
    logic             r_hdrOk;
    logic             r_monopoly;
    logic             r_err;
    logic [7:0]       r_txByte;
    logic [31:0]      r_usiWd;
    logic             r_usiWEd;
    logic             r_usiRCke;
    logic             r_rdPend;
    logic             r_rdHave;
    logic             r_rdTo;
    logic [31:0]      r_rdData;
    logic [TMR_W-1:0] r_rdTimer;
    logic [1:0]       r_txCnt;
    logic [31:0]      r_ufiWd;
    logic [31:0]      r_ufiAdrs;
    logic             r_ufiWEd;
    logic             r_ufiWVd;
    logic [31:0]      r_pAdrs;
    logic [15:0]      r_remain;

    logic [15:0]      w_len;
    logic             w_hdrOk;
    logic [7:0]       w_rdByte;
    logic             w_pkVd;
    logic             w_pkLast;
    logic             w_pkClear;
    logic [31:0]      w_pkWord;
    logic             w_pkDone;

    assign w_len     = {r_len[7:0], bus.iRxByte};
    assign w_pkVd    = bus.iRxVd && bus.iSpiCsAct && ((r_state == ST_CWR) || (r_state == ST_PWR));
    assign w_pkLast  = (r_state == ST_PWR) && (r_remain == 16'd1);
    assign w_pkClear = (r_state == ST_HDR);

    // Header validation against the length byte arriving this cycle
    always_comb begin
        w_hdrOk = 1'b0;
        case (r_cmd)
            CMD_NON:                w_hdrOk = 1'b0;
            CMD_CSR_WR, CMD_CSR_RD: w_hdrOk = (w_len == CSR_LEN);
            CMD_PSRAM_WR:           w_hdrOk = ({1'b0, w_len} <= MAX_LEN);
            default:                w_hdrOk = 1'b0;
        endcase
    end

    // Read data byte selected by the MISO byte index, MSB first
    always_comb begin
        w_rdByte = r_rdData[31:24];
        case (r_txCnt)
            2'd0:    w_rdByte = r_rdData[31:24];
            2'd1:    w_rdByte = r_rdData[23:16];
            2'd2:    w_rdByte = r_rdData[15:8];
            default: w_rdByte = r_rdData[7:0];
        endcase
    end

    spi_word_packer u_packer (
        .i_clk      (iSysClk),
        .i_rst_n    (iSysRst),
        .i_clear    (w_pkClear),
        .i_byteVd   (w_pkVd),
        .i_byte     (bus.iRxByte),
        .i_last     (w_pkLast),
        .o_word     (w_pkWord),
        .o_wordDone (w_pkDone)
    );

    // Sequencer FSM with all bus outputs registered; CS loss aborts from any state
    always_ff @(posedge iSysClk or negedge iSysRst) begin
        if (!iSysRst) begin
            r_state    <= ST_IDLE;
            r_csPrev   <= 1'b0;
            r_hdrCnt   <= '0;
            r_adrs     <= '0;
            r_cmd      <= '0;
            r_len      <= '0;
            r_hdrOk    <= 1'b0;
            r_monopoly <= 1'b0;
            r_err      <= 1'b0;
            r_txByte   <= PAD_BYTE;
            r_usiWd    <= '0;
            r_usiWEd   <= 1'b0;
            r_usiRCke  <= 1'b0;
            r_rdPend   <= 1'b0;
            r_rdHave   <= 1'b0;
            r_rdTo     <= 1'b0;
            r_rdData   <= '0;
            r_rdTimer  <= '0;
            r_txCnt    <= '0;
            r_ufiWd    <= '0;
            r_ufiAdrs  <= '0;
            r_ufiWEd   <= 1'b0;
            r_ufiWVd   <= 1'b0;
            r_pAdrs    <= '0;
            r_remain   <= '0;
        end else begin
            r_csPrev  <= bus.iSpiCsAct;
            r_usiWEd  <= 1'b0;
            r_usiRCke <= 1'b0;
            r_ufiWEd  <= 1'b0;
            if (bus.iTxReq) r_txByte <= PAD_BYTE;

            if (r_rdPend) begin
                if (bus.iMUsiREd) begin
                    r_rdData <= bus.iMUsiRd;
                    r_rdHave <= 1'b1;
                    r_rdPend <= 1'b0;
                end else if (r_rdTimer == TMR_LAST) begin
                    r_rdTo   <= 1'b1;
                    r_rdPend <= 1'b0;
                    r_err    <= 1'b1;
                end else begin
                    r_rdTimer <= r_rdTimer + TMR_W'(1);
                end
            end

            if ((r_state != ST_IDLE) && !bus.iSpiCsAct) begin
                r_state    <= ST_IDLE;
                r_monopoly <= 1'b0;
                r_ufiWVd   <= 1'b0;
                r_rdPend   <= 1'b0;
                r_rdHave   <= 1'b0;
                r_rdTo     <= 1'b0;
                r_txByte   <= PAD_BYTE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.iSpiCsAct && !r_csPrev) begin
                            r_state  <= ST_HDR;
                            r_hdrCnt <= '0;
                            r_txCnt  <= '0;
                            r_rdPend <= 1'b0;
                            r_rdHave <= 1'b0;
                            r_rdTo   <= 1'b0;
                        end
                    end
                    ST_HDR: begin
                        if (bus.iRxVd) begin
                            r_hdrCnt <= r_hdrCnt + 3'd1;
                            case (r_hdrCnt)
                                3'd0, 3'd1, 3'd2, 3'd3: r_adrs <= {r_adrs[23:0], bus.iRxByte};
                                3'd4: begin
                                    r_cmd <= bus.iRxByte;
                                    if (isCsrCmd(bus.iRxByte)) r_monopoly <= 1'b1;
                                end
                                3'd5: r_len <= w_len;
                                3'd6: begin
                                    r_len   <= w_len;
                                    r_hdrOk <= w_hdrOk;
                                    r_err   <= !w_hdrOk;
                                    if (w_hdrOk && (r_cmd == CMD_CSR_RD)) begin
                                        r_usiRCke <= 1'b1;
                                        r_rdPend  <= 1'b1;
                                        r_rdTimer <= '0;
                                    end
                                end
                                3'(HDR_BYTES - 1): begin
                                    if (!r_hdrOk) begin
                                        r_state <= ST_DISCARD;
                                    end else if (r_cmd == CMD_CSR_WR) begin
                                        r_state <= ST_CWR;
                                    end else if (r_cmd == CMD_CSR_RD) begin
                                        r_state <= ST_CRD;
                                    end else if (r_len == 16'd0) begin
                                        r_state <= ST_DISCARD;
                                    end else begin
                                        r_state  <= ST_PWR;
                                        r_pAdrs  <= r_adrs;
                                        r_remain <= r_len;
                                        r_ufiWVd <= 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_CWR: begin
                        if (w_pkDone) begin
                            r_usiWd  <= w_pkWord;
                            r_usiWEd <= 1'b1;
                            r_state  <= ST_DISCARD;
                        end
                    end
                    ST_CRD: begin
                        if (bus.iTxReq) begin
                            if (r_rdHave) begin
                                r_txByte <= w_rdByte;
                            end else if (r_rdTo) begin
                                r_txByte <= ERR_BYTE;
                            end else begin
                                r_txByte <= PAD_BYTE;
                                r_err    <= 1'b1;
                            end
                            r_txCnt <= r_txCnt + 2'd1;
                            if (r_txCnt == 2'd3) r_state <= ST_DISCARD;
                        end
                    end
                    ST_PWR: begin
                        if (w_pkVd) begin
                            r_remain <= r_remain - 16'd1;
                            if (w_pkDone) begin
                                r_ufiWd   <= w_pkWord;
                                r_ufiAdrs <= r_pAdrs;
                                r_pAdrs   <= r_pAdrs + 32'd4;
                                r_ufiWEd  <= 1'b1;
                            end
                            if (r_remain == 16'd1) r_state <= ST_DISCARD;
                        end
                    end
                    ST_DISCARD: r_ufiWVd <= 1'b0;
                    default:    r_state  <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.oTxByte       = r_txByte;
    assign bus.oMUsiWd       = r_usiWd;
    assign bus.oMUsiAdrs     = r_adrs[pUsiAdrsBit-1:0];
    assign bus.oMUsiWEd      = r_usiWEd;
    assign bus.oMUsiRCke     = r_usiRCke;
    assign bus.oMUfiWd       = r_ufiWd;
    assign bus.oMUfiAdrs     = r_ufiAdrs;
    assign bus.oMUfiWEd      = r_ufiWEd;
    assign bus.oMUfiWVd      = r_ufiWVd;
    assign bus.oMUsiMonopoly = r_monopoly;
    assign bus.oErr          = r_err;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer: expected bus transfers and MISO
// bytes are queued as frames are driven and popped when the DUT produces them.
module tb_spi_cmd_sequencer;

    typedef struct packed {
        logic [31:0] adrs;
        logic [31:0] data;
    } xfer_t;

    logic clk = 1'b0;
    logic rst_n;

    int checks     = 0;
    int failures   = 0;
    int usiWeCount = 0;
    int ufiWeCount = 0;
    int rckeCount  = 0;
    int rdCountdown = 0;
    logic        rdRespond  = 1'b1;
    logic [31:0] rdRespData = 32'h0102_0304;

    xfer_t       usiQ[$];
    xfer_t       ufiQ[$];
    logic [15:0] rckeQ[$];
    logic [7:0]  misoQ[$];

    always #5 clk = ~clk;

    spi_cmd_sequencer_if #(.pUsiAdrsBit(16)) bus ();

    spi_cmd_sequencer #(
        .pUsiAdrsBit (16),
        .pMaxLen     (2048),
        .pRdTimeout  (255)
    ) dut (
        .iSysClk (clk),
        .iSysRst (rst_n),
        .bus     (bus.slave)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Bus monitor and CSR read responder; pops the scoreboard on every strobe
    always @(negedge clk) begin
        bus.iMUsiREd = 1'b0;
        bus.iMUsiRd  = 32'h0;
        if (rst_n === 1'b1) begin
            if (rdCountdown > 0) begin
                rdCountdown = rdCountdown - 1;
                if (rdCountdown == 0) begin
                    bus.iMUsiRd  = rdRespData;
                    bus.iMUsiREd = 1'b1;
                end
            end
            if (bus.oMUsiRCke === 1'b1) begin
                rckeCount++;
                if (rckeQ.size() == 0) checkOutput("rcke_unexpected", 64'd1, 64'd0);
                else checkOutput("rcke_adrs", 64'(bus.oMUsiAdrs), 64'(rckeQ.pop_front()));
                if (rdRespond) rdCountdown = 3;
            end
            if (bus.oMUsiWEd === 1'b1) begin
                usiWeCount++;
                if (usiWQempty()) checkOutput("usi_we_unexpected", 64'd1, 64'd0);
                else checkOutput("usi_write", {16'h0, bus.oMUsiAdrs, bus.oMUsiWd}, usiQ.pop_front());
            end
            if (bus.oMUfiWEd === 1'b1) begin
                ufiWeCount++;
                checkOutput("ufi_wvd_at_we", 64'(bus.oMUfiWVd), 64'd1);
                if (ufiQ.size() == 0) checkOutput("ufi_we_unexpected", 64'd1, 64'd0);
                else checkOutput("ufi_write", {bus.oMUfiAdrs, bus.oMUfiWd}, ufiQ.pop_front());
            end
        end
    end

    function automatic logic usiWQempty();
        return usiQ.size() == 0;
    endfunction

    // One MOSI byte: a single iRxVd strobe followed by an idle cycle
    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        bus.iRxByte = b;
        bus.iRxVd   = 1'b1;
        @(negedge clk);
        bus.iRxVd   = 1'b0;
        @(negedge clk);
    endtask

    task automatic sendHeader(input logic [31:0] adrs, input logic [7:0] cmd, input logic [15:0] len);
        @(negedge clk);
        bus.iSpiCsAct = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(adrs[31:24]);
        applyStimulus(adrs[23:16]);
        applyStimulus(adrs[15:8]);
        applyStimulus(adrs[7:0]);
        applyStimulus(cmd);
        applyStimulus(len[15:8]);
        applyStimulus(len[7:0]);
        applyStimulus(8'h00);
    endtask

    task automatic endFrame();
        repeat (2) @(negedge clk);
        bus.iSpiCsAct = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Request one MISO byte and compare it on the cycle after iTxReq
    task automatic misoByte(input logic [7:0] expected);
        misoQ.push_back(expected);
        @(negedge clk);
        bus.iTxReq = 1'b1;
        @(negedge clk);
        bus.iTxReq = 1'b0;
        checkOutput("miso_byte", 64'(bus.oTxByte), 64'(misoQ.pop_front()));
        @(negedge clk);
    endtask

    task automatic csrWrite(input logic [15:0] adrs, input logic [31:0] data);
        usiQ.push_back({16'h0, adrs, data});
        sendHeader({16'h0, adrs}, 8'h01, 16'd4);
        for (int i = 3; i >= 0; i--) applyStimulus(data[i*8 +: 8]);
    endtask

    int baseCount;

    initial begin
        rst_n         = 1'b0;
        bus.iSpiCsAct = 1'b0;
        bus.iRxByte   = 8'h00;
        bus.iRxVd     = 1'b0;
        bus.iTxReq    = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_txbyte", 64'(bus.oTxByte), 64'h0);
        checkOutput("rst_flags", {59'h0, bus.oMUsiWEd, bus.oMUsiRCke, bus.oMUfiWEd, bus.oMUfiWVd, bus.oMUsiMonopoly}, 64'h0);
        checkOutput("rst_err", 64'(bus.oErr), 64'h0);
        checkOutput("rst_ufi_adrs", 64'(bus.oMUfiAdrs), 64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] CSR write");
        baseCount = usiWeCount;
        usiQ.push_back({32'h0000_1234, 32'hDEAD_BEEF});
        sendHeader(32'h0000_1234, 8'h01, 16'd4);
        checkOutput("cwr_monopoly", 64'(bus.oMUsiMonopoly), 64'd1);
        applyStimulus(8'hDE);
        applyStimulus(8'hAD);
        applyStimulus(8'hBE);
        applyStimulus(8'hEF);
        checkOutput("cwr_monopoly_end", 64'(bus.oMUsiMonopoly), 64'd1);
        checkOutput("cwr_err", 64'(bus.oErr), 64'd0);
        endFrame();
        checkOutput("cwr_count", 64'(usiWeCount - baseCount), 64'd1);
        checkOutput("cwr_monopoly_idle", 64'(bus.oMUsiMonopoly), 64'd0);

        $display("[TB] CSR read");
        rdRespond  = 1'b1;
        rdRespData = 32'h0102_0304;
        rckeQ.push_back(16'h0040);
        sendHeader(32'h0000_0040, 8'h02, 16'd4);
        repeat (4) @(negedge clk);
        misoByte(8'h01);
        misoByte(8'h02);
        misoByte(8'h03);
        misoByte(8'h04);
        checkOutput("crd_err", 64'(bus.oErr), 64'd0);
        endFrame();

        $display("[TB] PSRAM write");
        baseCount = ufiWeCount;
        ufiQ.push_back({32'h0000_1000, 32'h0001_0203});
        ufiQ.push_back({32'h0000_1004, 32'h0405_0607});
        ufiQ.push_back({32'h0000_1008, 32'h0809_0000});
        sendHeader(32'h0000_1000, 8'h03, 16'd10);
        checkOutput("pwr_wvd", 64'(bus.oMUfiWVd), 64'd1);
        for (int i = 0; i < 10; i++) applyStimulus(8'(i));
        checkOutput("pwr_wvd_done", 64'(bus.oMUfiWVd), 64'd0);
        endFrame();
        checkOutput("pwr_count", 64'(ufiWeCount - baseCount), 64'd3);

        $display("[TB] invalid headers");
        baseCount = usiWeCount;
        sendHeader(32'h0000_0010, 8'h01, 16'd8);
        for (int i = 0; i < 4; i++) applyStimulus(8'hA0 + 8'(i));
        checkOutput("inv_cwr_err", 64'(bus.oErr), 64'd1);
        endFrame();
        checkOutput("inv_cwr_count", 64'(usiWeCount - baseCount), 64'd0);
        baseCount = ufiWeCount;
        sendHeader(32'h0000_2000, 8'h03, 16'd2049);
        for (int i = 0; i < 4; i++) applyStimulus(8'hB0 + 8'(i));
        checkOutput("inv_pwr_err", 64'(bus.oErr), 64'd1);
        endFrame();
        checkOutput("inv_pwr_count", 64'(ufiWeCount - baseCount), 64'd0);
        csrWrite(16'h0055, 32'h1122_3344);
        checkOutput("err_cleared", 64'(bus.oErr), 64'd0);
        endFrame();

        $display("[TB] CS abort");
        baseCount = ufiWeCount;
        ufiQ.push_back({32'h0000_3000, 32'h0001_0203});
        sendHeader(32'h0000_3000, 8'h03, 16'd10);
        for (int i = 0; i < 6; i++) applyStimulus(8'(i));
        checkOutput("abort_wvd_before", 64'(bus.oMUfiWVd), 64'd1);
        @(negedge clk);
        bus.iSpiCsAct = 1'b0;
        @(negedge clk);
        checkOutput("abort_wvd_after", 64'(bus.oMUfiWVd), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("abort_count", 64'(ufiWeCount - baseCount), 64'd1);
        baseCount = usiWeCount;
        csrWrite(16'h0077, 32'hCAFE_F00D);
        endFrame();
        checkOutput("abort_next_frame", 64'(usiWeCount - baseCount), 64'd1);

        $display("[TB] read timeout and reset");
        rdRespond = 1'b0;
        rckeQ.push_back(16'h0044);
        sendHeader(32'h0000_0044, 8'h02, 16'd4);
        repeat (300) @(negedge clk);
        for (int i = 0; i < 4; i++) misoByte(8'hFF);
        checkOutput("timeout_err", 64'(bus.oErr), 64'd1);
        checkOutput("timeout_monopoly", 64'(bus.oMUsiMonopoly), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_monopoly", 64'(bus.oMUsiMonopoly), 64'd0);
        checkOutput("arst_err", 64'(bus.oErr), 64'd0);
        checkOutput("arst_adrs", 64'(bus.oMUsiAdrs), 64'd0);
        checkOutput("arst_txbyte", 64'(bus.oTxByte), 64'd0);
        checkOutput("arst_ufi", {bus.oMUfiAdrs, bus.oMUfiWd}, 64'd0);
        repeat (2) @(negedge clk);
        bus.iSpiCsAct = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        baseCount = usiWeCount;
        csrWrite(16'h0099, 32'h5566_7788);
        endFrame();
        checkOutput("post_reset_write", 64'(usiWeCount - baseCount), 64'd1);

        checkOutput("usiQ_empty", 64'(usiQ.size()), 64'd0);
        checkOutput("ufiQ_empty", 64'(ufiQ.size()), 64'd0);
        checkOutput("rckeQ_empty", 64'(rckeQ.size()), 64'd0);
        checkOutput("rcke_total", 64'(rckeCount), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_cmd_sequencer.md
Name: spi_cmd_sequencer

Overview:
Command sequencer between the SPI slave byte shifter and the internal buses. It parses the 8-byte header (4-byte address, command byte, 2-byte length, dummy) from the SPI byte stream, then issues Usi CSR writes and reads, or streams Ufi (PSRAM) write words. It drives bus monopoly for CSR commands and supplies MISO bytes for CSR reads.

Parameters:
pUsiAdrsBit, 16, Usi address width (CSR address = header address[pUsiAdrsBit-1:0])
pMaxLen, 2048, maximum PSRAM write length in bytes
pRdTimeout, 255, system clocks to wait for iMUsiREd before aborting a CSR read

Ports:
iSysClk  in  1  system clock
iSysRst  in  1  asynchronous, active-low reset
iSpiCsAct  in  1  chip select active, already synchronised; 1 = frame in progress
iRxByte  in  8  received MOSI byte
iRxVd  in  1  one-cycle strobe, iRxByte valid
iTxReq  in  1  one-cycle strobe, shifter needs the next MISO byte
oTxByte  out  8  next MISO byte; sampled by the shifter on iTxReq+1
oMUsiWd  out  32  CSR write data
oMUsiAdrs  out  pUsiAdrsBit  CSR address for read and write
oMUsiWEd  out  1  CSR write strobe, one cycle
oMUsiRCke  out  1  CSR read request strobe, one cycle
iMUsiRd  in  32  CSR read data
iMUsiREd  in  1  CSR read data valid
oMUfiWd  out  32  PSRAM write word
oMUfiAdrs  out  32  PSRAM byte address of the word
oMUfiWEd  out  1  PSRAM word strobe
oMUfiWVd  out  1  high during the PSRAM transfer
oMUsiMonopoly  out  1  1 = Usi bus owned by SPI master
oErr  out  1  sticky error flag; cleared by the next valid header

Behaviour:
- Reset: all outputs 0 (oTxByte 8'h00). State IDLE. Counters 0.
- Byte order: all header fields and data words are MSB-first. Address = bytes 0-3, Cmd = byte 4, Length = bytes 5-6, byte 7 is dummy.
- States:
  - IDLE: on iSpiCsAct rise -> HDR.
  - HDR: count iRxVd 0..7.
    - At byte 4: if Cmd is 1 or 2, set oMUsiMonopoly.
    - At byte 6: validate the header. Cmd 1 or 2 require Length==4. Cmd 3 requires Length<=pMaxLen. Cmd 0 and Cmd>3 are invalid.
    - Invalid header: set oErr and go to DISCARD after byte 7.
    - Valid Cmd 2: pulse oMUsiRCke with oMUsiAdrs on the cycle after byte 6.
    - After byte 7: Cmd1 -> CWR, Cmd2 -> CRD, Cmd3 -> PWR (Length 0 -> DISCARD).
  - CWR: shift 4 bytes into oMUsiWd. On the 4th iRxVd, pulse oMUsiWEd for 1 cycle (latency 1 clock from the strobe), then -> DISCARD.
  - CRD: wait for iMUsiREd and latch iMUsiRd. Each iTxReq presents the next byte (MSB first) on oTxByte the following cycle.
    - If data has not arrived by an iTxReq, send 8'h00 and set oErr.
    - Timeout of pRdTimeout cycles from the request: set oErr, serve 8'hFF bytes.
    - After 4 bytes -> DISCARD.
  - PWR: oMUfiWVd=1. Pack bytes into a word.
    - On every 4th byte, or on the final byte (remaining count==0), pulse oMUfiWEd.
    - A trailing partial word is padded with zeros in the low bytes.
    - oMUfiAdrs starts at the header address and increments by 4 per word (32-bit wrap). Then -> DISCARD.
  - DISCARD: ignore bytes, oTxByte=8'h00; on iSpiCsAct fall -> IDLE.
- oMUsiMonopoly clears on the return to IDLE.
- iSpiCsAct fall in any state: -> IDLE next cycle.
  - Partial words and incomplete CSR writes are dropped with no strobe.
  - oMUfiWVd and oMUsiMonopoly drop at the same time.
  - A pending CSR read response is ignored.
- iRxVd and iTxReq in the same cycle: both are handled.
- The Ufi bus accepts one word per cycle; there is no backpressure.
- Async reset mid-frame: immediate return to the reset state. The frame is lost until the next CS rise.

Decomposition:
- Shared package spi_cmd_pkg holds:
  - the state enum
  - Cmd codes: CMD_NON=0, CMD_CSR_WR=1, CMD_CSR_RD=2, CMD_PSRAM_WR=3
  - HDR_BYTES=8
  - the CSR fixed length, 4
  - pad and error fill bytes, 8'h00 and 8'hFF
- One sub-module, spi_word_packer: byte-to-32-bit shifter with byte count, last-byte flush and zero pad. Used by both CWR and PWR.

Test Plan:
- CSR write. Header 00 00 12 34 | 01 | 00 04 | 00, data DE AD BE EF -> a single oMUsiWEd, oMUsiAdrs=16'h1234, oMUsiWd=32'hDEADBEEF, oMUsiMonopoly high for the frame, oErr=0.
- CSR read. Header 00 00 00 40 | 02 | 00 04 | 00; iMUsiREd with 32'h0102_0304 three cycles after oMUsiRCke -> MISO bytes 01 02 03 04.
- PSRAM write. Addr 32'h0000_1000, Cmd 3, Length 10, bytes 00..09 -> three words:
  - 0x00010203 @1000
  - 0x04050607 @1004
  - 0x08090000 @1008
  - oMUfiWVd spans all three words.
- Invalid header. Cmd 1 with Length 8, and separately Cmd 3 with Length 2049 -> no strobes, oErr=1. oErr clears after a following valid frame.
- CS abort. Drop CS after 6 of 10 PSRAM data bytes -> exactly 1 word emitted; oMUfiWVd falls with CS; the next frame parses correctly.
- Read timeout and reset. iMUsiREd never arrives -> MISO FF FF FF FF and oErr=1. Asserting iSysRst low mid-frame returns all outputs to 0 immediately.
